clk_div_sel: RTL and testbench

//  Runtime-selectable, glitch-free synchronous clock divider. Produces clk_out
//  at clk_in/2^(k+1) for k = 0..CNT_W-1, and lets the selection be changed on the fly.
//  A change takes effect only on the common all-bits-wrap boundary, so no runt

---
 rtl/clk_div_sel.sv | 133 +++++++++++++
 tb/tb_clk_div_sel.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_sel.sv
// Runtime-selectable glitch-free clock divider: clk_out = clk_in / 2^(cur_sel+1).
// Define CLK_DIV_SEL_GATE_EN to add clk_en, which gates clk_out/tick one whole period at a time.
module clk_div_sel #(
   parameter int CNT_W     = 4,
   parameter int SEL_W     = 3,
   parameter int RESET_SEL = 0
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             sel_req,
   input  logic [SEL_W-1:0] sel_in,
`ifdef CLK_DIV_SEL_GATE_EN
   input  logic             clk_en,
`endif
   output logic             sel_ack,
   output logic             sel_busy,
   output logic             sel_err,
   output logic [SEL_W-1:0] cur_sel,
   output logic             clk_out,
   output logic             tick
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
   logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             wrap;
   logic             sel_bad;
`ifdef CLK_DIV_SEL_GATE_EN
   logic             gate_q, gate_d;
`endif

   assign wrap    = (cnt_q == CNT_MAX);
   assign sel_bad = (32'(sel_in) >= CNT_W);

   always_comb begin
      state_d    = state_q;
      cur_sel_d  = cur_sel_q;
      pend_sel_d = pend_sel_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      cnt_d      = cnt_q + CNT_ONE;

      case (state_q)
         IDLE: begin
            if (sel_req) begin
               if (sel_bad) begin
                  err_d = 1'b1;
               end else if (sel_in == cur_sel_q) begin
                  ack_d = 1'b1;
               end else begin
                  pend_sel_d = sel_in;
                  state_d    = PEND;
               end
            end
         end
         PEND: begin
            // All counter bits fall together on the wrap, so switching here cannot cut a phase short.
            if (wrap) begin
               cur_sel_d = pend_sel_q;
               ack_d     = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d    = (state_d == PEND);
      clk_out_d = |(cnt_d & (CNT_ONE << cur_sel_d));
`ifdef CLK_DIV_SEL_GATE_EN
      gate_d = wrap ? ~clk_en : gate_q;
      if (gate_d) begin
         clk_out_d = 1'b0;
      end
`endif
      tick_d = clk_out_d & ~clk_out_q;
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cur_sel_q  <= SEL_W'(RESET_SEL);
         pend_sel_q <= '0;
         clk_out_q  <= 1'b0;
         tick_q     <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cur_sel_q  <= cur_sel_d;
         pend_sel_q <= pend_sel_d;
         clk_out_q  <= clk_out_d;
         tick_q     <= tick_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
      end
   end

`ifdef CLK_DIV_SEL_GATE_EN
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         gate_q <= 1'b0;
      end else begin
         gate_q <= gate_d;
      end
   end
`endif

   assign sel_ack  = ack_q;
   assign sel_busy = busy_q;
   assign sel_err  = err_q;
   assign cur_sel  = cur_sel_q;
   assign clk_out  = clk_out_q;
   assign tick     = tick_q;

endmodule

// File: tb/tb_clk_div_sel.sv
// Bench for clk_div_sel: period-level reference model checked every cycle, plus directed literal checks.
module tb_clk_div_sel;

   localparam int CNT_W  = 4;
   localparam int SEL_W  = 3;
   localparam int PERIOD = 1 << CNT_W;

   logic             clk_in = 1'b0;
   logic             rst;
   logic             sel_req;
   logic [SEL_W-1:0] sel_in;
   logic             clk_en;
   logic             sel_ack, sel_busy, sel_err, clk_out, tick;
   logic [SEL_W-1:0] cur_sel;

   int checks = 0;
   int errors = 0;

   clk_div_sel #(.CNT_W(CNT_W), .SEL_W(SEL_W), .RESET_SEL(0)) dut (
      .clk_in  (clk_in),
      .rst     (rst),
      .sel_req (sel_req),
      .sel_in  (sel_in),
`ifdef CLK_DIV_SEL_GATE_EN
      .clk_en  (clk_en),
`endif
      .sel_ack (sel_ack),
      .sel_busy(sel_busy),
      .sel_err (sel_err),
      .cur_sel (cur_sel),
      .clk_out (clk_out),
      .tick    (tick)
   );

   always #5 clk_in = ~clk_in;

   // Reference model: phase counter, active ratio, one pending request, gate flag.
   int m_cnt = 0, m_sel = 0, m_pend = 0;
   bit m_busy = 0, m_gate = 0, e_ack = 0, e_err = 0, e_clk = 0, e_tick = 0;
   bit m_wrap, m_nclk;

   always @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         m_cnt = 0; m_sel = 0; m_pend = 0; m_busy = 0; m_gate = 0;
         e_ack = 0; e_err = 0; e_clk = 0; e_tick = 0;
      end else begin
         m_wrap = (m_cnt == PERIOD - 1);
         e_ack  = 0;
         e_err  = 0;
         if (m_busy) begin
            if (m_wrap) begin
               m_sel  = m_pend;
               e_ack  = 1;
               m_busy = 0;
            end
         end else if (sel_req) begin
            if (int'(sel_in) >= CNT_W) e_err = 1;
            else if (int'(sel_in) == m_sel) e_ack = 1;
            else begin
               m_pend = int'(sel_in);
               m_busy = 1;
            end
         end
`ifdef CLK_DIV_SEL_GATE_EN
         if (m_wrap) m_gate = !clk_en;
`endif
         m_cnt  = (m_cnt + 1) % PERIOD;
         m_nclk = m_gate ? 1'b0 : (((m_cnt / (1 << m_sel)) % 2) == 1);
         e_tick = m_nclk && !e_clk;
         e_clk  = m_nclk;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk_in) begin
      chk("cyc_cur_sel", int'(cur_sel), m_sel);
      chk("cyc_clk_out", int'(clk_out), int'(e_clk));
      chk("cyc_tick",    int'(tick),    int'(e_tick));
      chk("cyc_ack",     int'(sel_ack), int'(e_ack));
      chk("cyc_err",     int'(sel_err), int'(e_err));
      chk("cyc_busy",    int'(sel_busy), int'(m_busy));
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic wait_cnt(input int v);
      int n = 0;
      do begin
         step();
         n++;
      end while (m_cnt != v && n < 4 * PERIOD);
      if (m_cnt != v) begin
         checks++;
         errors++;
         $display("FAIL wait_cnt timeout: got cnt %0d expected %0d", m_cnt, v);
      end
   endtask

   task automatic pulse_req(input int s);
      sel_in  = SEL_W'(s);
      sel_req = 1'b1;
      step();
      sel_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; sel_req = 1'b0; sel_in = '0; clk_en = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      chk("rst_clk_out", int'(clk_out), 0);
      chk("rst_cur_sel", int'(cur_sel), 0);
      chk("rst_busy", int'(sel_busy), 0);
      rst = 1'b1;

      // Divide-by-2 after reset: clk_out and tick both high on odd counts.
      for (int i = 0; i < 4; i++) begin
         step();
         $display("t1 cycle %0d clk_out=%0d tick=%0d", i, clk_out, tick);
         chk("t1_clk_out", int'(clk_out), (i % 2 == 0) ? 1 : 0);
         chk("t1_tick", int'(tick), (i % 2 == 0) ? 1 : 0);
      end

      // Switch to k=3 requested at cnt=5, completes on the wrap.
      wait_cnt(5);
      pulse_req(3);
      $display("t2 req sel=3 busy=%0d", sel_busy);
      chk("t2_busy_cnt6", int'(sel_busy), 1);
      wait_cnt(15);
      chk("t2_busy_cnt15", int'(sel_busy), 1);
      chk("t2_cur_sel_old", int'(cur_sel), 0);
      step();
      $display("t2 wrap ack=%0d cur_sel=%0d", sel_ack, cur_sel);
      chk("t2_ack", int'(sel_ack), 1);
      chk("t2_cur_sel", int'(cur_sel), 3);
      chk("t2_busy_off", int'(sel_busy), 0);
      chk("t2_clk_low", int'(clk_out), 0);
      repeat (7) step();
      chk("t2_clk_low_cnt7", int'(clk_out), 0);
      step();
      chk("t2_clk_high_cnt8", int'(clk_out), 1);
      chk("t2_tick_cnt8", int'(tick), 1);

      // Out-of-range request, then a same-ratio request.
      step();
      pulse_req(5);
      $display("t3 req sel=5 err=%0d", sel_err);
      chk("t3_err", int'(sel_err), 1);
      chk("t3_cur_sel", int'(cur_sel), 3);
      chk("t3_busy", int'(sel_busy), 0);
      step();
      chk("t3_err_once", int'(sel_err), 0);
      pulse_req(3);
      $display("t3 req sel=3 (same) ack=%0d", sel_ack);
      chk("t3_same_ack", int'(sel_ack), 1);
      chk("t3_same_busy", int'(sel_busy), 0);

      // Second request while busy is ignored.
      wait_cnt(2);
      pulse_req(2);
      pulse_req(1);
      $display("t4 pending sel=2, ignored sel=1 busy=%0d", sel_busy);
      chk("t4_busy", int'(sel_busy), 1);
      chk("t4_no_ack", int'(sel_ack), 0);
      wait_cnt(0);
      chk("t4_ack", int'(sel_ack), 1);
      chk("t4_cur_sel", int'(cur_sel), 2);
      repeat (2 * PERIOD) step();
      chk("t4_cur_sel_stays", int'(cur_sel), 2);

      // Reset while a request is pending.
      wait_cnt(8);
      pulse_req(3);
      chk("t5_busy", int'(sel_busy), 1);
      #2 rst = 1'b0;
      #1;
      $display("t5 reset mid-pend busy=%0d cur_sel=%0d clk_out=%0d", sel_busy, cur_sel, clk_out);
      chk("t5_busy_clr", int'(sel_busy), 0);
      chk("t5_cur_sel", int'(cur_sel), 0);
      chk("t5_clk_out", int'(clk_out), 0);
      @(posedge clk_in);
      #1 rst = 1'b1;
      for (int i = 0; i < 2 * PERIOD; i++) begin
         step();
         if (sel_ack !== 1'b0) chk("t5_no_ack", int'(sel_ack), 0);
      end
      chk("t5_cur_sel_final", int'(cur_sel), 0);

`ifdef CLK_DIV_SEL_GATE_EN
      // Gate one full period, then resume.
      wait_cnt(14);
      clk_en = 1'b0;
      step();
      step();
      clk_en = 1'b1;
      for (int i = 0; i < PERIOD; i++) begin
         chk("t6_gated_clk", int'(clk_out), 0);
         chk("t6_gated_tick", int'(tick), 0);
         if (i < PERIOD - 1) step();
      end
      $display("t6 gated period done");
      step();
      chk("t6_resume_cnt0", int'(clk_out), 0);
      step();
      chk("t6_resume_clk", int'(clk_out), 1);
      chk("t6_resume_tick", int'(tick), 1);
`endif

      repeat (4) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
